div_issue_ctrl: RTL and testbench

Two-port round-robin issue controller for the pipelined restoring fraction divider (`divide_r`). It accepts fraction-divide requests from two requesters and issues at most one per cycle into the divider. It tracks each in-flight operation in a latency-matched sideband pipe and returns results in issue order through a credit-protected response FIFO. The divider cannot stall, so no result is ever dropped. It sits between the FPU divide sequencer and the mantissa divider datapath.

---
 rtl/div_ctrl_pkg.sv | 27 ++
 rtl/div_rsp_fifo.sv | 56 +++++
 rtl/div_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and latency helper for the divider issue controller
package div_ctrl_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_TAG_W = 4;

    typedef struct packed {
        logic                 vld;
        logic                 port;
        logic [DIV_TAG_W-1:0] tag;
        logic                 err;
    } sb_entry_t;

    typedef struct packed {
        logic [DIV_W-1:0]     quot;
        logic                 sticky;
        logic                 err;
        logic                 port;
        logic [DIV_TAG_W-1:0] tag;
    } rsp_entry_t;

    // The divider registers its inputs on the first stage, so results trail by one less than STAGES.
    function automatic int div_lat(input int stages);
        return stages - 1;
    endfunction

endpackage

// File: rtl/div_rsp_fifo.sv
// rtl/div_rsp_fifo.sv - generic synchronous FIFO with full/empty/count
module div_rsp_fifo #(
    parameter int DEPTH = 14,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - two-port round-robin issue controller for the pipelined fraction divider
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH      = DIV_W,
    parameter int STAGES     = 12,
    parameter int TAG_W      = DIV_TAG_W,
    parameter int FIFO_DEPTH = STAGES + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num,
    input  logic [WIDTH-1:0] req0_den,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num,
    input  logic [WIDTH-1:0] req1_den,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    input  logic [WIDTH-1:0] div_quot,
    input  logic             div_sticky,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quot,
    output logic             rsp_sticky,
    output logic             rsp_err,
    output logic             rsp_port,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int LAT   = div_lat(STAGES);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int RSP_W = $bits(rsp_entry_t);

    if (WIDTH != DIV_W || TAG_W != DIV_TAG_W || LAT < 1 || FIFO_DEPTH < LAT + 2) begin : g_param_check
        $error("div_issue_ctrl: unsupported parameter set");
    end

    logic [OCC_W-1:0] occ;
    logic             rr;
    logic             credit_ok;
    logic             acc0;
    logic             acc1;
    logic             issue;
    logic             issue_port;
    logic             issue_err;
    logic             pop;
    logic [WIDTH-1:0] sel_num;
    logic [WIDTH-1:0] sel_den;
    logic [TAG_W-1:0] sel_tag;
    sb_entry_t        sb_in;
    sb_entry_t        pipe [LAT];
    sb_entry_t        tail;
    rsp_entry_t       cap;
    rsp_entry_t       head;
    logic [RSP_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic             fifo_unused;

    // Credit is judged on registered occupancy so a same-cycle pop never opens a slot early.
    assign credit_ok  = (occ < OCC_W'(FIFO_DEPTH));
    assign req0_ready = rst && credit_ok && (!req1_valid || !rr);
    assign req1_ready = rst && credit_ok && (!req0_valid || rr);
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign issue      = acc0 || acc1;
    assign issue_port = !acc0;

    assign sel_num   = issue_port ? req1_num : req0_num;
    assign sel_den   = issue_port ? req1_den : req0_den;
    assign sel_tag   = issue_port ? req1_tag : req0_tag;
    assign issue_err = (sel_den == '0) || (sel_num > sel_den);

    always_comb begin
        div_num    = '0;
        div_den    = '0;
        sb_in      = '0;
        sb_in.vld  = issue;
        sb_in.port = issue_port;
        sb_in.tag  = sel_tag;
        sb_in.err  = issue_err;
        if (issue) begin
            div_num = issue_err ? '0 : sel_num;
            div_den = issue_err ? '1 : sel_den;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i].vld <= 1'b0;
            rr  <= 1'b0;
            occ <= '0;
        end else begin
            pipe[0] <= sb_in;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (issue) rr <= !issue_port;
            occ <= occ + OCC_W'(issue) - OCC_W'(pop);
        end
    end

    // Rejected operands still flow through the divider; their result is replaced here.
    assign tail       = pipe[LAT-1];
    assign cap.quot   = tail.err ? '0 : div_quot;
    assign cap.sticky = tail.err ? 1'b0 : div_sticky;
    assign cap.err    = tail.err;
    assign cap.port   = tail.port;
    assign cap.tag    = tail.tag;

    div_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RSP_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tail.vld),
        .push_data (cap),
        .pop       (pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_unused = fifo_full ^ (^fifo_count);

    assign head       = rsp_entry_t'(head_bits);
    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_quot   = head.quot;
    assign rsp_sticky = head.sticky;
    assign rsp_err    = head.err;
    assign rsp_port   = head.port;
    assign rsp_tag    = head.tag;
    assign busy       = (occ != '0);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - randomized and directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

    localparam int WIDTH  = 8;
    localparam int STAGES = 12;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = STAGES + 2;
    localparam int LAT    = STAGES - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_num, req0_den, req1_num, req1_den;
    logic [TAG_W-1:0] req0_tag, req1_tag, rsp_tag;
    logic [WIDTH-1:0] div_num, div_den, div_quot, rsp_quot;
    logic             div_sticky, rsp_valid, rsp_ready, rsp_sticky, rsp_err, rsp_port, busy;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num(req0_num),
        .req0_den(req0_den), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num(req1_num),
        .req1_den(req1_den), .req1_tag(req1_tag),
        .div_num(div_num), .div_den(div_den), .div_quot(div_quot), .div_sticky(div_sticky),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot),
        .rsp_sticky(rsp_sticky), .rsp_err(rsp_err), .rsp_port(rsp_port), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    // Fraction quotient num/den scaled by 2^WIDTH; top bit of the result is the sticky remainder flag.
    function automatic logic [WIDTH:0] golden_div(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] a, dd, q, r;
        if (d == '0) return '0;
        a  = {n, {WIDTH{1'b0}}};
        dd = {{WIDTH{1'b0}}, d};
        q  = a / dd;
        r  = a % dd;
        return {r != '0, q[WIDTH-1:0]};
    endfunction

    // Divider stand-in: LAT edges from operands to result.
    logic [WIDTH-1:0] dq [LAT];
    logic             ds [LAT];
    always @(posedge clk) begin
        {ds[0], dq[0]} <= golden_div(div_num, div_den);
        for (int i = 1; i < LAT; i++) begin
            dq[i] <= dq[i-1];
            ds[i] <= ds[i-1];
        end
    end
    assign div_quot   = dq[LAT-1];
    assign div_sticky = ds[LAT-1];

    typedef struct {
        int               due;
        logic [WIDTH-1:0] quot;
        logic             sticky;
        logic             err;
        logic             port;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t mq[$];
    int   cyc, m_rr, vectors, miscompares, dut_pops;
    logic s_rv, s_rdy0, s_rdy1, s_acc0, s_acc1, s_err, s_sticky, s_port, s_busy;
    logic [WIDTH-1:0] s_quot;
    logic [TAG_W-1:0] s_tag;
    logic [TAG_W-1:0] got_tags[$];
    logic             got_errs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle();
        logic             credit, e_rdy0, e_rdy1, e_acc0, e_acc1, e_rv, e_err, p;
        logic [WIDTH-1:0] n, d, e_num, e_den;
        logic [TAG_W-1:0] t;
        logic [WIDTH:0]   g;
        exp_t             e;
        @(negedge clk);
        credit = rst && (mq.size() < DEPTH);
        e_rdy0 = credit && !(req1_valid && m_rr == 1);
        e_rdy1 = credit && !(req0_valid && m_rr == 0);
        e_acc0 = req0_valid && e_rdy0;
        e_acc1 = req1_valid && e_rdy1;
        e_rv   = (mq.size() != 0) && (mq[0].due <= cyc);
        p      = e_acc1;
        n      = p ? req1_num : req0_num;
        d      = p ? req1_den : req0_den;
        t      = p ? req1_tag : req0_tag;
        e_err  = (d == 0) || (n > d);
        e_num  = 0;
        e_den  = 0;
        if (e_acc0 || e_acc1) begin
            e_num = e_err ? 8'h00 : n;
            e_den = e_err ? 8'hff : d;
        end

        s_rv = rsp_valid; s_rdy0 = req0_ready; s_rdy1 = req1_ready;
        s_acc0 = req0_valid && req0_ready; s_acc1 = req1_valid && req1_ready;
        s_quot = rsp_quot; s_sticky = rsp_sticky; s_err = rsp_err; s_port = rsp_port;
        s_tag = rsp_tag; s_busy = busy;
        if (s_rv && rsp_ready) begin
            dut_pops++;
            got_tags.push_back(s_tag);
            got_errs.push_back(s_err);
        end

        check("req0_ready", req0_ready, e_rdy0);
        check("req1_ready", req1_ready, e_rdy1);
        check("rsp_valid", rsp_valid, e_rv);
        check("busy", busy, mq.size() != 0);
        check("div_num", div_num, e_num);
        check("div_den", div_den, e_den);
        if (e_rv) begin
            check("rsp_quot", rsp_quot, mq[0].quot);
            check("rsp_sticky", rsp_sticky, mq[0].sticky);
            check("rsp_err", rsp_err, mq[0].err);
            check("rsp_port", rsp_port, mq[0].port);
            check("rsp_tag", rsp_tag, mq[0].tag);
        end

        if (!rst) begin
            mq.delete();
            m_rr = 0;
        end else begin
            if (e_rv && rsp_ready) void'(mq.pop_front());
            if (e_acc0 || e_acc1) begin
                g        = golden_div(n, d);
                e.due    = cyc + STAGES;
                e.quot   = e_err ? '0 : g[WIDTH-1:0];
                e.sticky = e_err ? 1'b0 : g[WIDTH];
                e.err    = e_err;
                e.port   = p;
                e.tag    = t;
                mq.push_back(e);
                m_rr = p ? 0 : 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        for (int i = 0; i < 200 && (mq.size() != 0 || busy); i++) run_cycle();
        check("drain_busy", busy, 0);
    endtask

    task automatic single_op(input logic [TAG_W-1:0] tag, output int lat);
        req0_valid = 1; req0_num = 8'h40; req0_den = 8'h80; req0_tag = tag;
        rsp_ready = 1;
        run_cycle();
        check("single_accept", s_acc0, 1);
        req0_valid = 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            run_cycle();
            if (s_rv) begin
                lat = n;
                break;
            end
        end
        check("single_latency", lat, STAGES);
        check("single_quot", s_quot, 8'h80);
        check("single_sticky", s_sticky, 0);
        check("single_tag", s_tag, tag);
        check("single_port", s_port, 0);
        check("single_err", s_err, 0);
    endtask

    initial begin
        int lat, accepts, wait_n, seen;
        logic [TAG_W-1:0] exp_tags [8];
        logic             exp_errs [4];
        cyc = 0; m_rr = 0; vectors = 0; miscompares = 0; dut_pops = 0;
        rst = 0; rsp_ready = 0;
        req0_valid = 0; req0_num = 0; req0_den = 0; req0_tag = 0;
        req1_valid = 0; req1_num = 0; req1_den = 0; req1_tag = 0;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        check("reset_rdy0", s_rdy0, 0);
        check("reset_rdy1", s_rdy1, 0);
        check("reset_rsp_valid", s_rv, 0);
        check("reset_busy", s_busy, 0);
        rst = 1;

        single_op(4'd3, lat);
        drain();

        // rr is 1 after the port-0 single op, so port 1 wins first.
        got_tags.delete();
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req0_num = 8'(i * 8);  req0_den = 8'h80; req0_tag = 4'(i);
            req1_valid = 1; req1_num = 8'(i * 3 + 1); req1_den = 8'h33; req1_tag = 4'(8 + i);
            run_cycle();
            check("arb_grant", {s_acc1, s_acc0}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        drain();
        exp_tags = '{4'd8, 4'd1, 4'd10, 4'd3, 4'd12, 4'd5, 4'd14, 4'd7};
        check("arb_rsp_count", got_tags.size(), 8);
        for (int i = 0; i < 8 && i < got_tags.size(); i++) check("arb_rsp_tag", got_tags[i], exp_tags[i]);

        got_errs.delete();
        got_tags.delete();
        req0_valid = 1; req0_num = 8'h20; req0_den = 8'h40; req0_tag = 1; run_cycle(); req0_valid = 0;
        req1_valid = 1; req1_num = 8'h10; req1_den = 8'h00; req1_tag = 2; run_cycle();
        req1_num = 8'h90; req1_den = 8'h20; req1_tag = 3; run_cycle(); req1_valid = 0;
        req0_valid = 1; req0_num = 8'h30; req0_den = 8'h60; req0_tag = 4; run_cycle();
        drain();
        exp_errs = '{1'b0, 1'b1, 1'b1, 1'b0};
        check("illegal_rsp_count", got_errs.size(), 4);
        for (int i = 0; i < 4 && i < got_errs.size(); i++) begin
            check("illegal_err", got_errs[i], exp_errs[i]);
            check("illegal_tag", got_tags[i], 4'(i + 1));
        end

        rsp_ready = 0;
        accepts = 0;
        for (int i = 0; i < 30; i++) begin
            req0_valid = 1; req0_num = 8'($urandom_range(0, 100)); req0_den = 8'd100; req0_tag = 4'(i);
            req1_valid = 1; req1_num = 8'($urandom_range(0, 200)); req1_den = 8'd200; req1_tag = 4'(i + 1);
            run_cycle();
            if (s_acc0 || s_acc1) accepts++;
        end
        check("bp_accepts", accepts, DEPTH);
        check("bp_rdy0_low", s_rdy0, 0);
        check("bp_rdy1_low", s_rdy1, 0);
        rsp_ready = 1;
        wait_n = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (s_acc0 || s_acc1) break;
            wait_n++;
        end
        check("bp_resume_delay", wait_n, 1);
        drain();

        for (int i = 0; i < 5; i++) begin
            req0_valid = 1; req0_num = 8'h11; req0_den = 8'h22; req0_tag = 4'(i);
            run_cycle();
        end
        req0_valid = 0;
        rst = 0;
        run_cycle();
        rst = 1;
        run_cycle();
        check("rst_mid_busy", s_busy, 0);
        check("rst_mid_rsp_valid", s_rv, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            run_cycle();
            if (s_rv) seen++;
        end
        check("rst_mid_no_rsp", seen, 0);
        single_op(4'd9, lat);
        drain();

        dut_pops = 0;
        for (int i = 0; i < 10000; i++) begin
            logic stall;
            stall = ((i / 200) % 4) == 3;
            req0_valid = $urandom_range(0, 99) < 60;
            req1_valid = $urandom_range(0, 99) < 60;
            req0_den = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            req1_den = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            req0_num = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, int'(req0_den)));
            req1_num = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, int'(req1_den)));
            req0_tag = 4'($urandom);
            req1_tag = 4'($urandom);
            rsp_ready = stall ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 70);
            run_cycle();
        end
        drain();
        check("soak_wraps", dut_pops >= 100 * DEPTH, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
